button_pulse_gen: RTL

//   Front end for the start/stop counter: turns two raw, bouncy, asynchronous

---
 rtl/button_pulse_gen_if.sv | 19 +
 rtl/button_pulse_gen.sv | 105 ++++++++++
 2 files changed

// File: rtl/button_pulse_gen_if.sv
// Button-to-pulse front-end signal bundle: raw buttons in, debounced pulses and levels out.
interface button_pulse_gen_if;
    logic btn_start;
    logic btn_stop;
    logic start;
    logic stop;
    logic start_level;
    logic stop_level;

    modport master (
        output btn_start, btn_stop,
        input  start, stop, start_level, stop_level
    );

    modport slave (
        input  btn_start, btn_stop,
        output start, stop, start_level, stop_level
    );
endinterface

// File: rtl/button_pulse_gen.sv
// Debounces two async buttons into single-cycle start/stop pulses; stop wins on same-cycle qualification.
// Press-to-pulse latency DEBOUNCE_CYCLES+3 edges; no backpressure, pulses are fire-and-forget.
module button_pulse_gen #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter bit BTN_ACTIVE_HIGH = 1'b1
) (
    input  logic               clk,
    input  logic               reset_n,
    button_pulse_gen_if.slave  bus
);
    localparam int            CW       = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, ARM, HELD, REL} state_t;

    // Channel 0 is start, channel 1 is stop.
    state_t        state_q [2];
    state_t        state_d [2];
    logic [CW-1:0] cnt_q   [2];
    logic [CW-1:0] cnt_d   [2];
    logic [1:0]    btn;
    logic [1:0]    s1_q, s2_q;
    logic [1:0]    raw_pulse;
    logic [1:0]    level_d, level_q;
    logic          start_q, stop_q;

    assign btn = BTN_ACTIVE_HIGH ? {bus.btn_stop, bus.btn_start}
                                 : ~{bus.btn_stop, bus.btn_start};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_q    <= '0;
            s2_q    <= '0;
            level_q <= '0;
            start_q <= 1'b0;
            stop_q  <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                state_q[i] <= IDLE;
                cnt_q[i]   <= '0;
            end
        end else begin
            s1_q    <= btn;
            s2_q    <= s1_q;
            level_q <= level_d;
            start_q <= raw_pulse[0] & ~raw_pulse[1];
            stop_q  <= raw_pulse[1];
            for (int i = 0; i < 2; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
        end
    end

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            case (state_q[i])
                IDLE: if (s2_q[i]) begin
                    state_d[i] = ARM;
                    cnt_d[i]   = '0;
                end
                ARM: if (!s2_q[i]) begin
                    state_d[i] = IDLE;
                    cnt_d[i]   = '0;
                end else if (cnt_q[i] == CNT_LAST) begin
                    state_d[i] = HELD;
                    cnt_d[i]   = '0;
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
                HELD: if (!s2_q[i]) begin
                    state_d[i] = REL;
                    cnt_d[i]   = '0;
                end
                REL: if (s2_q[i]) begin
                    // A re-press during release qualification returns to HELD silently.
                    state_d[i] = HELD;
                    cnt_d[i]   = '0;
                end else if (cnt_q[i] == CNT_LAST) begin
                    state_d[i] = IDLE;
                    cnt_d[i]   = '0;
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
                default: begin
                    state_d[i] = IDLE;
                    cnt_d[i]   = '0;
                end
            endcase
        end
    end

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            raw_pulse[i] = (state_q[i] == ARM) && s2_q[i] && (cnt_q[i] == CNT_LAST);
            level_d[i]   = (state_d[i] == HELD) || (state_d[i] == REL);
        end
    end

    assign bus.start       = start_q;
    assign bus.stop        = stop_q;
    assign bus.start_level = level_q[0];
    assign bus.stop_level  = level_q[1];
endmodule
